// File: rtl/pc_pkg.sv
// pc_pkg: shared state/op types and enable priority decode for pc_seq
package pc_pkg;
  typedef enum logic {RUN, HALT} pc_state_e;
  typedef enum logic [2:0] {OP_INC, OP_REL, OP_ABS, OP_CALL, OP_RET} pc_op_e;
  function automatic pc_op_e decode_op(input logic ret, input logic call, input logic abs, input logic rel);
    return ret ? OP_RET : call ? OP_CALL : abs ? OP_ABS : rel ? OP_REL : OP_INC;
  endfunction
endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO return-address stack with count pointer
module pc_ret_stack #(
  parameter int D = 10,
  parameter int RS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int AW = RS_DEPTH > 1 ? $clog2(RS_DEPTH) : 1;
  logic [D-1:0] mem [RS_DEPTH];
  logic [CW-1:0] cnt;
  assign full = cnt == CW'(RS_DEPTH);
  assign empty = cnt == '0;
  assign top = empty ? '0 : mem[AW'(cnt - CW'(1))];
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (push && !full) begin
      mem[AW'(cnt)] <= push_data;
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) cnt <= cnt - CW'(1);
  end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: fetch-stage program counter with rel/LUT jumps, call/return stack, stall and halt
module pc_seq
  import pc_pkg::*;
#(
  parameter int D = 10,
  parameter int LUT_AW = 4,
  parameter int RS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              reljump_en,
  input  logic              absjump_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [D-1:0]      target,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [D-1:0]      lut_wdata,
  output logic [D-1:0]      prog_ctr,
  output logic              halted,
  output logic              rs_overflow,
  output logic              rs_underflow
);
  pc_state_e state;
  pc_op_e op;
  logic [D-1:0] lut [2**LUT_AW];
  logic [D-1:0] lut_val, pc_inc, pc_next, top;
  logic go, push, pop, full, empty;
  assign op = decode_op(ret_en, call_en, absjump_en, reljump_en);
  assign go = state == RUN && !stall && !halt_req;
  assign push = go && op == OP_CALL;
  assign pop = go && op == OP_RET;
  assign lut_val = lut[target[D-1 -: LUT_AW]];
  assign pc_inc = prog_ctr + D'(1);
  assign halted = state == HALT;
  always_comb begin
    pc_next = op == OP_RET ? (empty ? pc_inc : top) :
              (op == OP_CALL || op == OP_ABS) ? lut_val :
              op == OP_REL ? prog_ctr + target : pc_inc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr <= '0;
      state <= RUN;
      rs_overflow <= 1'b0;
      rs_underflow <= 1'b0;
      for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= D'(1) << (i % D);
    end else begin
      if (lut_we) lut[lut_waddr] <= lut_wdata;
      if (state == RUN && !stall && halt_req) state <= HALT;
      if (go) prog_ctr <= pc_next;
      if (push && full) rs_overflow <= 1'b1;
      if (pop && empty) rs_underflow <= 1'b1;
    end
  end
  pc_ret_stack #(.D(D), .RS_DEPTH(RS_DEPTH)) u_stack (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_data(pc_inc),
    .top(top),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed self-checking bench for pc_seq
module tb_pc_seq;
  logic clk = 0, reset = 1, stall = 0, halt_req = 0;
  logic reljump_en = 0, absjump_en = 0, call_en = 0, ret_en = 0, lut_we = 0;
  logic [9:0] target = 0, lut_wdata = 0, prog_ctr;
  logic [3:0] lut_waddr = 0;
  logic halted, rs_overflow, rs_underflow;
  int checks = 0, errors = 0;
  pc_seq dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en), .ret_en(ret_en),
    .target(target), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .halted(halted), .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
  );
  always #5 clk = ~clk;
  task tick();
    @(posedge clk);
    #1;
  endtask
  task clr();
    stall = 0; halt_req = 0; reljump_en = 0; absjump_en = 0; call_en = 0; ret_en = 0; lut_we = 0;
  endtask
  task chk_pc(input string name, input logic [9:0] exp);
    checks++;
    if (prog_ctr !== exp) begin
      errors++;
      $display("FAIL %s: prog_ctr=%0d expected %0d", name, prog_ctr, exp);
    end
  endtask
  task chk_flags(input string name, input logic h, input logic o, input logic u);
    checks++;
    if ({halted, rs_overflow, rs_underflow} !== {h, o, u}) begin
      errors++;
      $display("FAIL %s: halted/ovf/unf=%b%b%b expected %b%b%b", name, halted, rs_overflow, rs_underflow, h, o, u);
    end
  endtask
  task set_pc(input logic [9:0] v);
    lut_we = 1; lut_waddr = 15; lut_wdata = v;
    tick();
    lut_we = 0; absjump_en = 1; target = {4'hF, 6'd0};
    tick();
    absjump_en = 0;
  endtask
  task test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk_pc("reset_pc", 10'd0);
    chk_flags("reset_flags", 0, 0, 0);
  endtask
  task test_inc();
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_pc("inc", 10'(i));
    end
    set_pc(10'd1023);
    chk_pc("inc_pre_wrap", 10'd1023);
    tick();
    chk_pc("inc_wrap", 10'd0);
  endtask
  task test_rel();
    set_pc(10'd20);
    reljump_en = 1; target = 10'h3FD;
    tick();
    reljump_en = 0;
    chk_pc("rel_neg", 10'd17);
    set_pc(10'd1020);
    reljump_en = 1; target = 10'd5;
    tick();
    reljump_en = 0;
    chk_pc("rel_wrap", 10'd1);
  endtask
  task test_abs_lut();
    absjump_en = 1; target = {4'd3, 6'd0};
    tick();
    chk_pc("abs_default", 10'd8);
    lut_we = 1; lut_waddr = 3; lut_wdata = 10'd300;
    tick();
    lut_we = 0;
    chk_pc("abs_old_on_write", 10'd8);
    tick();
    absjump_en = 0;
    chk_pc("abs_new", 10'd300);
  endtask
  task test_call_ret();
    logic [3:0] idx [5];
    logic [9:0] dest [5];
    logic [9:0] pops [4];
    idx = '{4'd2, 4'd0, 4'd1, 4'd4, 4'd5};
    dest = '{10'd4, 10'd1, 10'd2, 10'd16, 10'd32};
    pops = '{10'd3, 10'd2, 10'd5, 10'd8};
    set_pc(10'd7);
    for (int i = 0; i < 5; i++) begin
      call_en = 1; target = {idx[i], 6'd0};
      chk_flags("call_pre_ovf", 0, 0, 0);
      tick();
      chk_pc("call_jump", dest[i]);
    end
    call_en = 0;
    chk_flags("call_ovf", 0, 1, 0);
    ret_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_pc("ret_pop", pops[i]);
    end
    chk_flags("ret_pre_unf", 0, 1, 0);
    tick();
    ret_en = 0;
    chk_pc("ret_empty", 10'd9);
    chk_flags("ret_unf", 0, 1, 1);
    tick();
    chk_flags("flags_sticky", 0, 1, 1);
  endtask
  task test_stall();
    set_pc(10'd100);
    stall = 1; absjump_en = 1; call_en = 1; halt_req = 1; target = {4'd2, 6'd0};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pc("stall_hold", 10'd100);
    end
    chk_flags("stall_no_halt", 0, 1, 1);
    stall = 0; halt_req = 0;
    tick();
    clr();
    chk_pc("stall_release_call", 10'd4);
    ret_en = 1;
    tick();
    ret_en = 0;
    chk_pc("stall_ret", 10'd101);
  endtask
  task test_halt();
    set_pc(10'd9);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk_pc("halt_pc", 10'd9);
    chk_flags("halt_flag", 1, 1, 1);
    reljump_en = 1; absjump_en = 1; call_en = 1; ret_en = 1; target = {4'd2, 6'd1};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pc("halt_hold", 10'd9);
    end
    clr();
    tick();
    chk_pc("halt_idle_hold", 10'd9);
    reset = 1;
    tick();
    reset = 0;
    chk_pc("rst_pc", 10'd0);
    chk_flags("rst_flags", 0, 0, 0);
    absjump_en = 1; target = {4'd3, 6'd0};
    tick();
    chk_pc("rst_lut3", 10'd8);
    target = {4'd15, 6'd0};
    tick();
    absjump_en = 0;
    chk_pc("rst_lut15", 10'd32);
  endtask
  initial begin
    clr();
    test_reset();
    test_inc();
    test_rel();
    test_abs_lut();
    test_call_ret();
    test_stall();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
